// File: rtl/usr_transfer_sequencer_if.sv
// rtl/usr_transfer_sequencer_if.sv - command/response and USR drive signal bundle
//
// Purpose: groups the command port, the response port and the USR drive/return
//          signals of usr_transfer_sequencer into one interface.
// Modports:
//   slave  - the sequencer: takes commands, returns responses, drives the USR
//   master - the environment: host issuing commands plus the USR instance
interface usr_transfer_sequencer_if #(
  parameter int SHIFT_LEN = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_mode;
  logic [3:0]           cmd_data;
  logic [SHIFT_LEN-1:0] cmd_sin;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [3:0]           rsp_data;
  logic [SHIFT_LEN-1:0] rsp_serial;
  logic                 rsp_err;

  logic                 usr_load;
  logic [2:0]           usr_shift_mode;
  logic [3:0]           usr_din;
  logic                 usr_sin;
  logic [3:0]           usr_dout;
  logic                 usr_sout;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_data, cmd_sin, rsp_ready, usr_dout, usr_sout,
    output cmd_ready, rsp_valid, rsp_data, rsp_serial, rsp_err,
           usr_load, usr_shift_mode, usr_din, usr_sin
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_data, cmd_sin, rsp_ready, usr_dout, usr_sout,
    input  cmd_ready, rsp_valid, rsp_data, rsp_serial, rsp_err,
           usr_load, usr_shift_mode, usr_din, usr_sin
  );
endinterface

// File: rtl/usr_transfer_sequencer.sv
// rtl/usr_transfer_sequencer.sv - command-driven sequencer for one 4-bit universal shift register
//
// Purpose: accepts a transfer command (mode, parallel word, serial-in bits), runs the USR
//          through LOAD, SHIFT_LEN shift cycles and DRAIN, and returns parallel and serial
//          results on a valid/ready response port. Mode 3'b111 is answered with rsp_err.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high (the USR shares it)
//   bus   - usr_transfer_sequencer_if.slave: cmd_*, rsp_*, usr_* signals
// Optional feature (macro USR_SEQ_CMD_BUF_EN): 1-entry command buffer so a new command
//   can be accepted while a transfer is in flight; cmd_ready = !buf_full.
module usr_transfer_sequencer #(
  parameter int SHIFT_LEN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  usr_transfer_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [2:0] MODE_PIPO = 3'b000;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  logic [2:0]           state;
  logic [2:0]           mode_q;
  logic [3:0]           data_q;
  logic [SHIFT_LEN-1:0] sin_buf;
  logic [3:0]           cnt;
  logic                 rsp_valid_q;
  logic [3:0]           rsp_data_q;
  logic [SHIFT_LEN-1:0] rsp_serial_q;
  logic                 rsp_err_q;

  logic                 cmd_ready_w;
  logic                 accept;
  logic                 rsp_hs;
  logic                 start;
  logic [2:0]           start_mode;
  logic [3:0]           start_data;
  logic [SHIFT_LEN-1:0] start_sin;

  assign accept = bus.cmd_valid && cmd_ready_w;
  assign rsp_hs = (state == S_RESP) && bus.rsp_ready;

`ifdef USR_SEQ_CMD_BUF_EN
  logic                 buf_full;
  logic [2:0]           buf_mode;
  logic [3:0]           buf_data;
  logic [SHIFT_LEN-1:0] buf_sin;
  logic                 take_input;

  assign cmd_ready_w = !buf_full;
  // The buffer is always empty in IDLE, so an incoming command starts directly there or
  // when it arrives exactly on a response handshake with nothing queued.
  assign take_input  = accept && ((state == S_IDLE) || (rsp_hs && !buf_full));

  always_comb begin
    start      = take_input;
    start_mode = bus.cmd_mode;
    start_data = bus.cmd_data;
    start_sin  = bus.cmd_sin;
    if (rsp_hs && buf_full) begin
      start      = 1'b1;
      start_mode = buf_mode;
      start_data = buf_data;
      start_sin  = buf_sin;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_mode <= 3'b000;
      buf_data <= 4'b0000;
      buf_sin  <= '0;
    end else begin
      if (rsp_hs && buf_full) begin
        buf_full <= 1'b0;
      end
      // A new command parked in the same cycle as a dequeue keeps the buffer full.
      if (accept && !take_input) begin
        buf_full <= 1'b1;
        buf_mode <= bus.cmd_mode;
        buf_data <= bus.cmd_data;
        buf_sin  <= bus.cmd_sin;
      end
    end
  end
`else
  assign cmd_ready_w = (state == S_IDLE);

  always_comb begin
    start      = accept;
    start_mode = bus.cmd_mode;
    start_data = bus.cmd_data;
    start_sin  = bus.cmd_sin;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      mode_q       <= 3'b000;
      data_q       <= 4'b0000;
      sin_buf      <= '0;
      cnt          <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 4'b0000;
      rsp_serial_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_LOAD: begin
          cnt   <= 4'd0;
          state <= (mode_q == MODE_PIPO) ? S_DRAIN : S_SHIFT;
        end
        S_SHIFT: begin
          sin_buf <= sin_buf >> 1;
          // usr_sout is registered, so the bit shifted out in cycle k shows up in cycle k+1.
          for (int k = 0; k < SHIFT_LEN - 1; k++) begin
            if (cnt == 4'(k + 1)) rsp_serial_q[k] <= bus.usr_sout;
          end
          if (cnt == 4'(SHIFT_LEN - 1)) state <= S_DRAIN;
          else                          cnt   <= cnt + 4'd1;
        end
        S_DRAIN: begin
          rsp_serial_q[SHIFT_LEN-1] <= bus.usr_sout;
          rsp_data_q                <= bus.usr_dout;
          rsp_valid_q               <= 1'b1;
          state                     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (start) begin
        mode_q       <= start_mode;
        data_q       <= start_data;
        sin_buf      <= start_sin;
        rsp_data_q   <= 4'b0000;
        rsp_serial_q <= '0;
        if (start_mode == MODE_RSVD) begin
          rsp_err_q   <= 1'b1;
          rsp_valid_q <= 1'b1;
          state       <= S_RESP;
        end else begin
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          state       <= S_LOAD;
        end
      end
    end
  end

  // Outside LOAD/SHIFT the USR is held by feeding its own output back in mode 000.
  always_comb begin
    bus.usr_load       = 1'b0;
    bus.usr_shift_mode = 3'b000;
    bus.usr_din        = bus.usr_dout;
    bus.usr_sin        = 1'b0;
    case (state)
      S_LOAD: begin
        bus.usr_load = 1'b1;
        bus.usr_din  = data_q;
      end
      S_SHIFT: begin
        bus.usr_shift_mode = mode_q;
        bus.usr_sin        = sin_buf[0];
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready  = cmd_ready_w;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_serial = rsp_serial_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_usr_transfer_sequencer.sv
// tb/tb_usr_transfer_sequencer.sv - self-checking bench for usr_transfer_sequencer with a USR model
module tb_usr_transfer_sequencer;
  localparam int L = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  usr_transfer_sequencer_if #(.SHIFT_LEN(L)) bus ();

  usr_transfer_sequencer #(.SHIFT_LEN(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural 4-bit USR: registered sout, dout gated after PISO/SISO operation.
  logic [3:0] usr_q;
  logic       usr_sout_q;
  logic [2:0] usr_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      usr_q <= 4'b0; usr_sout_q <= 1'b0; usr_last <= 3'b0;
    end else if (bus.usr_load) begin
      usr_q <= bus.usr_din; usr_sout_q <= 1'b0; usr_last <= 3'b000;
    end else begin
      case (bus.usr_shift_mode)
        3'b000: begin usr_q <= bus.usr_din;                 usr_sout_q <= 1'b0; end
        3'b001: begin usr_q <= {usr_q[2:0], bus.usr_sin};   usr_sout_q <= 1'b0; end
        3'b010: begin usr_q <= {bus.usr_sin, usr_q[3:1]};   usr_sout_q <= 1'b0; end
        3'b011: begin usr_q <= {usr_q[2:0], 1'b0};          usr_sout_q <= usr_q[3]; end
        3'b100: begin usr_q <= {1'b0, usr_q[3:1]};          usr_sout_q <= usr_q[0]; end
        3'b101: begin usr_q <= {usr_q[2:0], bus.usr_sin};   usr_sout_q <= usr_q[3]; end
        3'b110: begin usr_q <= {bus.usr_sin, usr_q[3:1]};   usr_sout_q <= usr_q[0]; end
        default: ;
      endcase
      if (bus.usr_shift_mode != 3'b000) usr_last <= bus.usr_shift_mode;
    end
  end

  assign bus.usr_dout = (usr_last >= 3'b011 && usr_last <= 3'b110) ? 4'b0000 : usr_q;
  assign bus.usr_sout = usr_sout_q;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: what one transfer returns, derived from the mode rules with plain arithmetic.
  function automatic void ref_model(input logic [2:0] m, input logic [3:0] d, input logic [L-1:0] s,
                                    output logic [3:0] rd, output logic [L-1:0] rs,
                                    output logic re, output int lat);
    int  q;
    bit  left, sin_used, out_used;
    rd = 4'b0; rs = '0; re = 1'b0;
    if (m == 3'b111) begin re = 1'b1; lat = 1; return; end
    if (m == 3'b000) begin rd = d; lat = 3; return; end
    lat = L + 3;
    q = int'(d);
    left     = (m == 3'b001) || (m == 3'b011) || (m == 3'b101);
    sin_used = (m == 3'b001) || (m == 3'b010) || (m == 3'b101) || (m == 3'b110);
    out_used = (m >= 3'b011);
    for (int k = 0; k < L; k++) begin
      int ob, ib;
      ob = left ? (q / 8) % 2 : q % 2;
      ib = sin_used ? int'(s[k]) : 0;
      if (out_used) rs[k] = ob[0];
      q = left ? ((q * 2) + ib) % 16 : (q / 2) + ib * 8;
    end
    if (!out_used) rd = 4'(q);
  endfunction

  task automatic send(input logic [2:0] m, input logic [3:0] d, input logic [L-1:0] s);
    int g = 0;
    bus.cmd_valid = 1'b1; bus.cmd_mode = m; bus.cmd_data = d; bus.cmd_sin = s;
    while (!bus.cmd_ready && g < 50) begin @(negedge clk); g++; end
    check("cmd_accept_timeout", 32'(g < 50), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output int lat, output logic [3:0] rd, output logic [L-1:0] rs,
                         output logic re, output bit load_seen, input bit do_hs);
    lat = 0; load_seen = 0;
    while (lat < 40) begin
      @(negedge clk); lat++;
      if (bus.usr_load) load_seen = 1;
      if (bus.rsp_valid) break;
    end
    check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
    rd = bus.rsp_data; rs = bus.rsp_serial; re = bus.rsp_err;
    if (do_hs) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0] mode; logic [3:0] data; logic [3:0] sin;
    logic [3:0] exp_data; logic [3:0] exp_serial; logic exp_err; int exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, exp_lat, seen;
    logic [3:0] rd, exp_rd;
    logic [L-1:0] rs, exp_rs;
    logic re, exp_re;
    bit ld;

    vecs[0] = '{3'b011, 4'b1011, 4'b0000, 4'b0000, 4'b1101, 1'b0, 7};
    vecs[1] = '{3'b001, 4'b0000, 4'b1011, 4'b1101, 4'b0000, 1'b0, 7};
    vecs[2] = '{3'b000, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 1'b0, 3};
    vecs[3] = '{3'b111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1};
    vecs[4] = '{3'b100, 4'b1011, 4'b0000, 4'b0000, 4'b1011, 1'b0, 7};
    vecs[5] = '{3'b010, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1'b0, 7};
    vecs[6] = '{3'b101, 4'b0110, 4'b1111, 4'b0000, 4'b0110, 1'b0, 7};
    vecs[7] = '{3'b110, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 1'b0, 7};

    bus.cmd_valid = 1'b0; bus.cmd_mode = 3'b0; bus.cmd_data = 4'b0; bus.cmd_sin = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_serial", 32'(bus.rsp_serial), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_usr_load", 32'(bus.usr_load), 32'd0);
    check("reset_usr_mode", 32'(bus.usr_shift_mode), 32'd0);
    check("reset_usr_sin", 32'(bus.usr_sin), 32'd0);
    check("idle_hold_din", 32'(bus.usr_din), 32'(bus.usr_dout));

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].mode, vecs[i].data, vecs[i].sin);
      get_rsp(lat, rd, rs, re, ld, 1'b0);
      check($sformatf("vec%0d_data", i), 32'(rd), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_serial", i), 32'(rs), 32'(vecs[i].exp_serial));
      check($sformatf("vec%0d_err", i), 32'(re), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].exp_err) check($sformatf("vec%0d_no_load", i), 32'(ld), 32'd0);
      if (vecs[i].mode == 3'b000) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("pipo_hold_valid", 32'(bus.rsp_valid), 32'd1);
          check("pipo_hold_data", 32'(bus.rsp_data), 32'hA);
          check("pipo_hold_serial", 32'(bus.rsp_serial), 32'd0);
`ifdef USR_SEQ_CMD_BUF_EN
          check("pipo_hold_cmd_ready", 32'(bus.cmd_ready), 32'd1);
`else
          check("pipo_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
`endif
        end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_released", i), 32'(bus.rsp_valid), 32'd0);
    end

    // Reset during SHIFT cycle 2 of a SISO-R transfer.
    send(3'b110, 4'b1001, 4'b0101);
    repeat (4) @(negedge clk);
    check("abort_in_shift_mode", 32'(bus.usr_shift_mode), 32'b110);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("abort_no_response", 32'(seen), 32'd0);

`ifdef USR_SEQ_CMD_BUF_EN
    bus.rsp_ready = 1'b1;
    send(3'b011, 4'b1011, 4'b0000);
    @(negedge clk);
    send(3'b011, 4'b0110, 4'b0000);
    @(negedge clk);
    check("buf_full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    lat = 2;
    while (!bus.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    check("buf_first_latency", 32'(lat), 32'd7);
    check("buf_first_serial", 32'(bus.rsp_serial), 32'b1101);
    @(negedge clk);
    check("buf_second_load", 32'(bus.usr_load), 32'd1);
    check("buf_second_valid_low", 32'(bus.rsp_valid), 32'd0);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    check("buf_second_latency", 32'(lat), 32'd7);
    check("buf_second_serial", 32'(bus.rsp_serial), 32'b0110);
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [2:0] m;
      logic [3:0] d;
      logic [L-1:0] s;
      m = 3'($urandom_range(0, 7));
      d = 4'($urandom);
      s = L'($urandom);
      ref_model(m, d, s, exp_rd, exp_rs, exp_re, exp_lat);
      send(m, d, s);
      get_rsp(lat, rd, rs, re, ld, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check($sformatf("rnd%0d_m%0d_data", i, m), 32'(bus.rsp_data), 32'(exp_rd));
      check($sformatf("rnd%0d_m%0d_serial", i, m), 32'(bus.rsp_serial), 32'(exp_rs));
      check($sformatf("rnd%0d_m%0d_err", i, m), 32'(bus.rsp_err), 32'(exp_re));
      check($sformatf("rnd%0d_m%0d_latency", i, m), 32'(lat), 32'(exp_lat));
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
